// File: rtl/instruction_loader.sv
// instruction_loader: boot-time byte-stream to instruction-memory writer.
// Assembles little-endian words and holds the core until the load is done.
//   clk, reset         : clock, async active-high reset
//   start, num_words   : begin a load of num_words (clamped to DEPTH)
//   byte_valid/ready   : byte handshake, byte_data is the payload
//   mem_we/waddr/wdata : one-cycle word write to instruction memory
//   cpu_hold           : core reset, released only in DONE
//   busy, done         : load in progress / load complete
//   words_written      : words committed in the current load
module instruction_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] MAXW = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  logic [1:0]      state;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_q;
  logic [ADDR_W:0] target;
  logic [ADDR_W:0] clamp;
  logic [ADDR_W:0] ww_nxt;

  // Clamping to DEPTH keeps the last write at DEPTH-1, so no wrap.
  assign clamp  = (num_words > MAXW) ? MAXW : num_words;
  assign ww_nxt = words_written + ONE;

  // All handshake/status outputs decode state only.
  assign byte_ready = (state == S_RECV);
  assign mem_we     = (state == S_WRITE);
  assign busy       = (state == S_RECV) || (state == S_WRITE);
  assign done       = (state == S_DONE);
  assign cpu_hold   = (state != S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      byte_idx      <= 2'd0;
      asm_q         <= '0;
      target        <= '0;
      words_written <= '0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            target        <= clamp;
            words_written <= '0;
            byte_idx      <= 2'd0;
            state         <= (clamp == '0) ? S_DONE : S_RECV;
          end
        end
        S_RECV: begin
          if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: asm_q[7:0]   <= byte_data;
              2'd1: asm_q[15:8]  <= byte_data;
              2'd2: asm_q[23:16] <= byte_data;
              2'd3: begin
                // Word address is the running count; the
                // write registers hold until the next word.
                mem_wdata <= {byte_data, asm_q};
                mem_waddr <= words_written[ADDR_W-1:0];
                state     <= S_WRITE;
              end
              default: ;
            endcase
          end
        end
        S_WRITE: begin
          words_written <= ww_nxt;
          byte_idx      <= 2'd0;
          state         <= (ww_nxt == target) ? S_DONE : S_RECV;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed and randomized load sequences checked
// against a byte-queue model of little-endian word assembly.
module tb_instruction_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   words_written;

  instruction_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_words     (num_words),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  int compared;
  int mism;
  int cyc;

  logic [7:0]        bq[$];
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  int                wc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_waddr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_cap();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic fill_random(input int n);
    bq.delete();
    repeat (n) bq.push_back(8'($urandom));
  endtask

  task automatic start_load(input int nw);
    start     = 1'b1;
    num_words = (ADDR_W+1)'(nw);
    @(negedge clk);
    start     = 1'b0;
  endtask

  // mode 0: valid held high, 1: alternate stalls, 2: random stalls
  task automatic stream(input int mode, input int mid_at);
    int idx = 0;
    int guard = 0;
    bit stall;
    bit rdy;
    bit mid_done = 1'b0;
    while (idx < bq.size() && done !== 1'b1 && guard < 6000) begin
      case (mode)
        1: stall = guard[0];
        2: stall = ($urandom_range(0, 9) < 3);
        default: stall = 1'b0;
      endcase
      byte_valid = !stall;
      byte_data  = stall ? 8'($urandom) : bq[idx];
      if (mid_at >= 0 && idx == mid_at && !mid_done) begin
        start     = 1'b1;
        num_words = 9'd5;
        mid_done  = 1'b1;
      end
      rdy = byte_ready;
      @(negedge clk);
      start = 1'b0;
      if (byte_valid && rdy) idx++;
      guard++;
    end
    byte_valid = 1'b0;
    chk("stream_budget", 64'(guard < 6000), 64'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 64'(done), 64'd1);
  endtask

  // Reference: word i is bytes 4i..4i+3, little-endian, at address i.
  task automatic check_writes(input string tag, input int n);
    logic [31:0] w;
    chk({tag, "_nwrites"}, 64'(wa.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wa.size()) begin
        w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
        chk({tag, "_addr"}, 64'(wa[i]), 64'(i));
        chk({tag, "_data"}, 64'(wd[i]), 64'(w));
      end
    end
  endtask

  task automatic check_done(input string tag, input int n);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rdy"}, 64'(byte_ready), 64'd0);
    chk({tag, "_ww"}, 64'(words_written), 64'(n));
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    num_words  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    #1;
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_waddr", 64'(mem_waddr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_rdy", 64'(byte_ready), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ww", 64'(words_written), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed two-word load, valid held high.
    bq = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    clear_cap();
    start_load(2);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_rdy", 64'(byte_ready), 64'd1);
    chk("start_hold", 64'(cpu_hold), 64'd1);
    stream(0, -1);
    wait_done();
    check_writes("dir", 2);
    if (wd.size() >= 2) begin
      chk("dir_w0", 64'(wd[0]), 64'h0050_0013);
      chk("dir_w1", 64'(wd[1]), 64'h00A0_0093);
      chk("dir_gap", 64'(wc[1] - wc[0]), 64'd5);
    end
    check_done("dir", 2);

    // Same stream with alternate-cycle stalls.
    clear_cap();
    start_load(2);
    stream(1, -1);
    wait_done();
    check_writes("alt", 2);
    check_done("alt", 2);

    // Randomized loads with random stalls.
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 8);
      fill_random(4 * n);
      clear_cap();
      start_load(n);
      stream(2, -1);
      wait_done();
      check_writes("rnd", n);
      check_done("rnd", n);
    end

    // Reset after word 0 and two bytes of word 1.
    fill_random(6);
    clear_cap();
    start_load(2);
    stream(0, -1);
    reset = 1'b1;
    #1;
    chk("mrst_hold", 64'(cpu_hold), 64'd1);
    chk("mrst_ww", 64'(words_written), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_we", 64'(mem_we), 64'd0);
    repeat (3) @(negedge clk);
    chk("mrst_nwrites", 64'(wa.size()), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    fill_random(12);
    clear_cap();
    start_load(3);
    stream(2, -1);
    wait_done();
    check_writes("reload", 3);
    check_done("reload", 3);

    // Zero-word load goes straight to DONE.
    clear_cap();
    start_load(0);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_hold", 64'(cpu_hold), 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_nwrites", 64'(wa.size()), 64'd0);
    chk("zero_ww", 64'(words_written), 64'd0);

    // Oversized request clamps to DEPTH writes.
    fill_random(4 * DEPTH + 4);
    clear_cap();
    start_load(300);
    stream(0, -1);
    wait_done();
    check_writes("big", DEPTH);
    if (wa.size() > 0)
      chk("big_last", 64'(wa[wa.size()-1]), 64'(DEPTH - 1));
    check_done("big", DEPTH);
    byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("big_norecv", 64'(byte_ready), 64'd0);
    end
    byte_valid = 1'b0;
    chk("big_nomore", 64'(wa.size()), 64'(DEPTH));

    // Start pulse in DONE reloads one word.
    fill_random(4);
    clear_cap();
    start_load(1);
    chk("dstart_hold", 64'(cpu_hold), 64'd1);
    chk("dstart_done", 64'(done), 64'd0);
    stream(2, -1);
    wait_done();
    check_writes("dstart", 1);
    check_done("dstart", 1);

    // Start pulse mid-RECV is ignored.
    fill_random(8);
    clear_cap();
    start_load(2);
    stream(0, 2);
    wait_done();
    check_writes("midstart", 2);
    check_done("midstart", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
